mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: WADDR_W, default 11, word-address width toward data memory; byte address width is WADDR_W+2.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 clock  in  1  sole clock, all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  1  pipeline requests a memory access this cycle.
REQ-006 req_ready  out  1  high when IDLE; a request is accepted only when req_valid && req_ready at a rising edge.
REQ-007 req_write  in  1  1 = store, 0 = load.
REQ-008 req_size  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
REQ-009 req_signed  in  1  loads: 1 = sign-extend, 0 = zero-extend; ignored for stores and word size.
REQ-010 req_addr  in  WADDR_W+2  byte address.
REQ-011 req_wdata  in  32  store data, right-justified for sub-word sizes.
REQ-012 rdata  out  32  extracted and extended load result.
REQ-013 rdata_valid  out  1  one-cycle pulse; rdata is valid in that cycle.
REQ-014 wr_done  out  1  one-cycle pulse when a store's memory write has completed.
REQ-015 misalign_err  out  1  one-cycle pulse on a rejected misaligned request (see REQ-031).
REQ-016 mem_address  out  WADDR_W  word address to data memory, equal to req_addr[WADDR_W+1:2].
REQ-017 mem_in_data  out  32  write word to data memory.
REQ-018 mem_write, mem_read  out  1 each  data-memory strobes, registered, never high together.
REQ-019 mem_out_data  in  32  read word from data memory; valid after the falling edge of a cycle with mem_read high.

Function
REQ-020 States: IDLE, RD, WR, RMW_RD, RMW_WR; state is held in a registered FSM.
REQ-021 IDLE on an accepted load goes to RD; on a word store to WR; on a byte or halfword store to RMW_RD; on a misaligned request stays in IDLE and pulses misalign_err in the next cycle.
REQ-022 RD: mem_read=1 for one cycle. The rising edge ending RD captures the extracted value into rdata and sets rdata_valid=1 for the next cycle. The FSM then returns to IDLE.
REQ-023 WR: mem_write=1 and mem_in_data=req_wdata for one cycle. wr_done pulses in the following cycle. The FSM then returns to IDLE.
REQ-024 RMW_RD: mem_read=1. At the closing edge the memory word is merged with the new byte or halfword into a 32-bit merge buffer, and the FSM moves to RMW_WR.
REQ-025 RMW_WR: mem_write=1 and mem_in_data=merge buffer. wr_done pulses in the following cycle. The FSM then returns to IDLE.
REQ-026 Latency from accept edge: a load gives rdata_valid 2 cycles later; a word store gives wr_done 2 cycles later; a sub-word store gives wr_done 3 cycles later.
REQ-027 Byte lanes are little-endian: lane n = bits [8n+7:8n], n = addr[1:0]; a halfword uses lanes addr[1]*2 and addr[1]*2+1.
REQ-028 Sign extension copies bit 7 (byte) or bit 15 (halfword) of the extracted value; zero extension fills 0.
REQ-029 All request fields are registered at accept; input changes while not IDLE are ignored.
REQ-030 req_valid while busy is not queued; the requester holds it until req_ready is high.
REQ-031 Misaligned means a halfword with addr[0]=1, or a word with addr[1:0]!=0.
REQ-032 Address wrap: no bounds check; mem_address is truncated to WADDR_W bits.

Reset
REQ-033 Reset forces IDLE; clears rdata, rdata_valid, wr_done, misalign_err, mem_write, mem_read, mem_address, mem_in_data and the merge buffer to 0; drives req_ready=1 after release.
REQ-034 Reset in any non-IDLE state abandons the operation: no memory write occurs and no done or valid pulse is produced.

Configuration
REQ-035 With MEMACC_MISALIGN_TRAP_EN defined, misaligned requests behave per REQ-021.
REQ-036 Without MEMACC_MISALIGN_TRAP_EN, low address bits are forced to alignment: addr[0] is cleared for halfwords and addr[1:0] for words. The access then proceeds normally, and misalign_err is tied to 0.

Structure
REQ-037 Package mem_access_pkg holds the size codes (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enumeration.
REQ-038 Sub-module mem_lane_align is purely combinational. It provides extract+extend for loads and merge for stores, and is instantiated once.

Verification
REQ-039 Word store 0xDEADBEEF @0x010, then word load @0x010 -> mem_address=4; wr_done 2 cycles after accept; rdata=0xDEADBEEF 2 cycles after load accept.
REQ-040 Memory word 4 = 0x11223344. Signed byte load @0x012 -> 0x00000022; unsigned halfword load @0x012 -> 0x00001122. Memory word 4 = 0x80FF0000, signed byte load @0x013 -> 0xFFFFFF80.
REQ-041 Memory word 4 = 0x11223344; byte store 0xAB @0x011 -> sequence mem_read then mem_write; word 4 becomes 0x1122AB44; wr_done 3 cycles after accept.
REQ-042 Halfword load @0x011 with the macro defined -> misalign_err pulse, mem_read/mem_write never high. With the macro undefined -> reads halfword @0x010, misalign_err=0.
REQ-043 reset_n driven low during RMW_RD of a byte store -> memory word unchanged, wr_done never pulses, req_ready=1 after release.
REQ-044 req_valid held during a busy load with a second request -> second request accepted only on the edge where req_ready=1, and both results are correct and in order.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared size codes, FSM state encoding and alignment helpers for the
// data-memory access controller.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RMW_RD,
    ST_RMW_WR
  } state_e;

  // Size code 2'b11 falls into the word branch in both helpers.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      default: return (lo != 2'b00);
    endcase
  endfunction

  function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return lo;
      SZ_HALF: return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: extract+extend for loads, merge of a
// byte/halfword into the fetched word for read-modify-write stores.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [1:0]  i_lo,
  input  logic [31:0] i_mem_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_mem_word[{i_lo, 3'b000} +: 8];
  assign w_half = i_lo[1] ? i_mem_word[31:16] : i_mem_word[15:0];

  always_comb begin
    o_load_data = i_mem_word;
    o_merged    = i_mem_word;
    case (i_size)
      SZ_BYTE: begin
        o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
        o_merged[{i_lo, 3'b000} +: 8] = i_wdata[7:0];
      end
      SZ_HALF: begin
        o_load_data = {{16{i_signed & w_half[15]}}, w_half};
        o_merged[{i_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
      end
      default: begin
        o_load_data = i_mem_word;
        o_merged    = i_wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller between a pipeline and a word-wide data memory.
// Define MEMACC_MISALIGN_TRAP_EN to reject misaligned requests instead of aligning them.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int WADDR_W = 11
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [1:0]         req_size,
  input  logic               req_signed,
  input  logic [WADDR_W+1:0] req_addr,
  input  logic [31:0]        req_wdata,
  output logic [31:0]        rdata,
  output logic               rdata_valid,
  output logic               wr_done,
  output logic               misalign_err,
  output logic [WADDR_W-1:0] mem_address,
  output logic [31:0]        mem_in_data,
  output logic               mem_write,
  output logic               mem_read,
  input  logic [31:0]        mem_out_data
);

  state_e             r_state, w_next;
  logic [1:0]         r_size;
  logic               r_signed;
  logic [WADDR_W+1:0] r_addr;
  logic [31:0]        r_wdata, r_merge, r_rdata;
  logic               r_rdata_valid, r_wr_done, r_mem_write, r_mem_read;
  logic               w_accept, w_mis;
  logic [WADDR_W+1:0] w_addr;
  logic               w_mem_read_nxt, w_mem_write_nxt, w_rdata_valid_nxt, w_wr_done_nxt;
  logic [31:0]        w_load_data, w_merged;

  assign w_accept = req_valid && (r_state == ST_IDLE);

`ifdef MEMACC_MISALIGN_TRAP_EN
  logic r_misalign;
  assign w_mis        = is_misaligned(req_size, req_addr[1:0]);
  assign w_addr       = req_addr;
  assign misalign_err = r_misalign;
`else
  assign w_mis        = 1'b0;
  assign w_addr       = {req_addr[WADDR_W+1:2], align_lo(req_size, req_addr[1:0])};
  assign misalign_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && !w_mis) begin
          if (!req_write)                                      w_next = ST_RD;
          else if (req_size == SZ_BYTE || req_size == SZ_HALF) w_next = ST_RMW_RD;
          else                                                 w_next = ST_WR;
        end
      end
      ST_RMW_RD: w_next = ST_RMW_WR;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Strobes are computed from the next state so they leave a flop aligned with the state.
  always_comb begin
    w_mem_read_nxt    = (w_next == ST_RD) || (w_next == ST_RMW_RD);
    w_mem_write_nxt   = (w_next == ST_WR) || (w_next == ST_RMW_WR);
    w_rdata_valid_nxt = (r_state == ST_RD);
    w_wr_done_nxt     = (r_state == ST_WR) || (r_state == ST_RMW_WR);
  end

  mem_lane_align u_align (
    .i_size      (r_size),
    .i_signed    (r_signed),
    .i_lo        (r_addr[1:0]),
    .i_mem_word  (mem_out_data),
    .i_wdata     (r_wdata),
    .o_load_data (w_load_data),
    .o_merged    (w_merged)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_size        <= SZ_BYTE;
      r_signed      <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_merge       <= '0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_wr_done     <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_read    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_size   <= req_size;
        r_signed <= req_signed;
        r_addr   <= w_addr;
        r_wdata  <= req_wdata;
      end
      if (r_state == ST_RMW_RD) r_merge <= w_merged;
      if (r_state == ST_RD)     r_rdata <= w_load_data;
      r_rdata_valid <= w_rdata_valid_nxt;
      r_wr_done     <= w_wr_done_nxt;
      r_mem_write   <= w_mem_write_nxt;
      r_mem_read    <= w_mem_read_nxt;
    end
  end

`ifdef MEMACC_MISALIGN_TRAP_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_misalign <= 1'b0;
    else          r_misalign <= w_accept && w_mis;
  end
`endif

  assign req_ready   = (r_state == ST_IDLE);
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign wr_done     = r_wr_done;
  assign mem_write   = r_mem_write;
  assign mem_read    = r_mem_read;
  assign mem_address = r_addr[WADDR_W+1:2];
  assign mem_in_data = (r_state == ST_RMW_WR) ? r_merge : r_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed, table-driven bench for mem_access_ctrl with a behavioural data memory.
module tb_mem_access_ctrl;

  logic        clock, reset_n, req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [12:0] req_addr;
  logic [31:0] req_wdata, rdata, mem_in_data, mem_out_data;
  logic        rdata_valid, wr_done, misalign_err, mem_write, mem_read;
  logic [10:0] mem_address;

  logic [31:0] mem [0:2047];
  int n_tests = 0;
  int n_fail  = 0;

  mem_access_ctrl #(.WADDR_W(11)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rdata(rdata), .rdata_valid(rdata_valid),
    .wr_done(wr_done), .misalign_err(misalign_err), .mem_address(mem_address),
    .mem_in_data(mem_in_data), .mem_write(mem_write), .mem_read(mem_read),
    .mem_out_data(mem_out_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: read data appears after the falling edge, writes land on the rising edge.
  initial mem_out_data = 32'h0;
  always @(negedge clock) if (mem_read) mem_out_data <= mem[mem_address];
  always @(posedge clock) if (mem_write) mem[mem_address] <= mem_in_data;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issues one request from idle and observes 8 cycles; cycle 0 ends at the accept edge.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [12:0] a, input logic [31:0] wd,
                         output int done_cyc, output logic [31:0] rd, output int rd_cyc,
                         output int wr_cyc, output logic [10:0] maddr, output bit both,
                         output int mis_cyc);
    @(negedge clock);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clock); #1;
    req_valid = 1'b0;
    done_cyc = -1; rd_cyc = -1; wr_cyc = -1; mis_cyc = -1;
    rd = 32'h0; maddr = 11'h0; both = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (mem_read && rd_cyc < 0) begin rd_cyc = c; maddr = mem_address; end
      if (mem_write && wr_cyc < 0) begin wr_cyc = c; maddr = mem_address; end
      if (mem_read && mem_write) both = 1'b1;
      if (misalign_err && mis_cyc < 0) mis_cyc = c;
      if ((rdata_valid || wr_done) && done_cyc < 0) begin done_cyc = c; rd = rdata; end
      @(posedge clock); #1;
    end
  endtask

  typedef struct {
    string       name;
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [12:0] a;
    logic [31:0] wd;
    logic [10:0] maddr;
    logic [31:0] pre;
    logic [31:0] exp_rd;
    logic [31:0] exp_mem;
    int          exp_done;
    int          exp_rdc;
    int          exp_wrc;
  } vec_t;

  vec_t v [15];

  int          done_cyc, rd_cyc, wr_cyc, mis_cyc;
  logic [31:0] rd;
  logic [10:0] maddr;
  bit          both;

  initial begin
    v[0]  = '{"st_word",    1'b1, 2'b10, 1'b0, 13'h010,  32'hDEADBEEF, 11'd4,     32'h00000000, 32'h0,        32'hDEADBEEF, 2, -1, 1};
    v[1]  = '{"ld_word",    1'b0, 2'b10, 1'b0, 13'h010,  32'h0,        11'd4,     32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 2, 1, -1};
    v[2]  = '{"ld_sb_012",  1'b0, 2'b00, 1'b1, 13'h012,  32'h0,        11'd4,     32'h11223344, 32'h00000022, 32'h11223344, 2, 1, -1};
    v[3]  = '{"ld_uh_012",  1'b0, 2'b01, 1'b0, 13'h012,  32'h0,        11'd4,     32'h11223344, 32'h00001122, 32'h11223344, 2, 1, -1};
    v[4]  = '{"ld_sb_013",  1'b0, 2'b00, 1'b1, 13'h013,  32'h0,        11'd4,     32'h80FF0000, 32'hFFFFFF80, 32'h80FF0000, 2, 1, -1};
    v[5]  = '{"ld_ub_013",  1'b0, 2'b00, 1'b0, 13'h013,  32'h0,        11'd4,     32'h80FF0000, 32'h00000080, 32'h80FF0000, 2, 1, -1};
    v[6]  = '{"ld_sh_012",  1'b0, 2'b01, 1'b1, 13'h012,  32'h0,        11'd4,     32'h80FF0000, 32'hFFFF80FF, 32'h80FF0000, 2, 1, -1};
    v[7]  = '{"ld_sh_010",  1'b0, 2'b01, 1'b1, 13'h010,  32'h0,        11'd4,     32'h12348001, 32'hFFFF8001, 32'h12348001, 2, 1, -1};
    v[8]  = '{"ld_ub_011",  1'b0, 2'b00, 1'b0, 13'h011,  32'h0,        11'd4,     32'h11223344, 32'h00000033, 32'h11223344, 2, 1, -1};
    v[9]  = '{"st_b_011",   1'b1, 2'b00, 1'b0, 13'h011,  32'h000000AB, 11'd4,     32'h11223344, 32'h0,        32'h1122AB44, 3, 1, 2};
    v[10] = '{"st_h_012",   1'b1, 2'b01, 1'b0, 13'h012,  32'h0000BEEF, 11'd4,     32'h11223344, 32'h0,        32'hBEEF3344, 3, 1, 2};
    v[11] = '{"st_b_010",   1'b1, 2'b00, 1'b0, 13'h010,  32'hFFFFFF5A, 11'd4,     32'h00000000, 32'h0,        32'h0000005A, 3, 1, 2};
    v[12] = '{"ld_sz11",    1'b0, 2'b11, 1'b1, 13'h014,  32'h0,        11'd5,     32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 2, 1, -1};
    v[13] = '{"ld_wrap",    1'b0, 2'b10, 1'b0, 13'h1FFC, 32'h0,        11'h7FF,   32'h80000001, 32'h80000001, 32'h80000001, 2, 1, -1};
    v[14] = '{"st_h_010_sg",1'b1, 2'b01, 1'b1, 13'h010,  32'h00008765, 11'd4,     32'hFFFFFFFF, 32'h0,        32'hFFFF8765, 3, 1, 2};

    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 13'h0; req_wdata = 32'h0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_flags", {28'h0, rdata_valid, wr_done, misalign_err, mem_write}, 32'h0);
    chk("rst_mem_read", {31'h0, mem_read}, 32'h0);
    chk("rst_mem_address", {21'h0, mem_address}, 32'h0);
    chk("rst_mem_in_data", mem_in_data, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);

    // Table-driven single transactions
    for (int i = 0; i < 15; i++) begin
      mem[v[i].maddr] = v[i].pre;
      run_req(v[i].w, v[i].sz, v[i].sg, v[i].a, v[i].wd, done_cyc, rd, rd_cyc, wr_cyc, maddr, both, mis_cyc);
      chk({v[i].name, "_latency"}, done_cyc, v[i].exp_done);
      chk({v[i].name, "_rd_cycle"}, rd_cyc, v[i].exp_rdc);
      chk({v[i].name, "_wr_cycle"}, wr_cyc, v[i].exp_wrc);
      chk({v[i].name, "_mem_address"}, {21'h0, maddr}, {21'h0, v[i].maddr});
      chk({v[i].name, "_strobe_overlap"}, {31'h0, both}, 32'h0);
      chk({v[i].name, "_misalign"}, mis_cyc, -1);
      chk({v[i].name, "_mem_word"}, mem[v[i].maddr], v[i].exp_mem);
      if (!v[i].w) chk({v[i].name, "_rdata"}, rd, v[i].exp_rd);
    end

    // Misaligned halfword load at 0x011
    mem[4] = 32'h11223344;
    run_req(1'b0, 2'b01, 1'b0, 13'h011, 32'h0, done_cyc, rd, rd_cyc, wr_cyc, maddr, both, mis_cyc);
`ifdef MEMACC_MISALIGN_TRAP_EN
    chk("mis_err_cycle", mis_cyc, 1);
    chk("mis_no_read", rd_cyc, -1);
    chk("mis_no_write", wr_cyc, -1);
    chk("mis_no_done", done_cyc, -1);
`else
    chk("mis_no_err", mis_cyc, -1);
    chk("mis_aligned_addr", {21'h0, maddr}, 32'd4);
    chk("mis_aligned_rdata", rd, 32'h00003344);
    chk("mis_latency", done_cyc, 2);
`endif
    chk("mis_ready", {31'h0, req_ready}, 32'h1);

    // Misaligned word store at 0x012
    mem[4] = 32'h11223344;
    run_req(1'b1, 2'b10, 1'b0, 13'h012, 32'hA5A5A5A5, done_cyc, rd, rd_cyc, wr_cyc, maddr, both, mis_cyc);
`ifdef MEMACC_MISALIGN_TRAP_EN
    chk("misw_err_cycle", mis_cyc, 1);
    chk("misw_mem_word", mem[4], 32'h11223344);
`else
    chk("misw_no_err", mis_cyc, -1);
    chk("misw_mem_word", mem[4], 32'hA5A5A5A5);
`endif

    // Reset during RMW_RD of a byte store
    mem[4] = 32'h11223344;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 13'h011; req_wdata = 32'h000000AB;
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("rstmid_in_rmw_rd", {30'h0, mem_read, req_ready}, 32'h2);
    #1 reset_n = 1'b0;
    #1;
    chk("rstmid_strobes_low", {30'h0, mem_read, mem_write}, 32'h0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    begin
      bit done_seen = 1'b0;
      for (int c = 0; c < 5; c++) begin
        @(posedge clock); #1;
        if (wr_done || mem_write) done_seen = 1'b1;
      end
      chk("rstmid_no_write_done", {31'h0, done_seen}, 32'h0);
    end
    chk("rstmid_mem_word", mem[4], 32'h11223344);
    chk("rstmid_ready", {31'h0, req_ready}, 32'h1);

    // Back-to-back requests with req_valid held through the busy cycle
    begin
      int          acc [2];
      logic [31:0] res [2];
      int          n_acc = 0;
      int          n_res = 0;
      logic        rdy, vld;
      acc[0] = -1; acc[1] = -1; res[0] = 32'h0; res[1] = 32'h0;
      mem[4] = 32'h11111111;
      mem[5] = 32'h00008000;
      @(negedge clock);
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
      req_addr = 13'h010; req_wdata = 32'h0;
      for (int c = 0; c < 10; c++) begin
        rdy = req_ready; vld = req_valid;
        @(posedge clock); #1;
        if (rdy && vld && n_acc < 2) begin
          acc[n_acc] = c;
          n_acc++;
          if (n_acc == 1) begin
            req_size = 2'b00; req_signed = 1'b1; req_addr = 13'h015;
          end else begin
            req_valid = 1'b0;
          end
        end
        if (rdata_valid && n_res < 2) begin
          res[n_res] = rdata;
          n_res++;
        end
        @(negedge clock);
      end
      req_valid = 1'b0;
      chk("b2b_first_accept", acc[0], 0);
      chk("b2b_second_accept", acc[1], 2);
      chk("b2b_result_count", n_res, 2);
      chk("b2b_first_rdata", res[0], 32'h11111111);
      chk("b2b_second_rdata", res[1], 32'hFFFFFF80);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
